dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port round-robin arbiter in front of the single-port, synchronous-read/synchronous-write data memory (N-bit word address, M-bit word).
- Port 0 is the core load/store unit. Port 1 is the program loader / debug access.
- Grants at most one access per cycle and steers the one-cycle-late read data back to the owning requester.

Parameters:
- N, 20, word-address width (memory depth 2^N).
- M, 32, data word width.
- STAT_W, 32, width of the statistics counters (used only with the optional feature).

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- p0_req  in  1  port 0 access request; held until granted.
- p0_we  in  1  port 0: 1 = write, 0 = read.
- p0_addr  in  N  port 0 word address.
- p0_wdata  in  M  port 0 write data.
- p0_gnt  out  1  port 0 granted this cycle (combinational).
- p0_rvalid  out  1  port 0 read data valid (registered).
- p0_rdata  out  M  port 0 read data.
- p1_req, p1_we, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata: same as port 0, for port 1.
- mem_we  out  1  memory write enable.
- mem_a  out  N  memory address.
- mem_wd  out  M  memory write data.
- mem_rd  in  M  memory read data; registered inside the memory, valid the cycle after the address.

Behaviour:
- Grant, combinational:
  - Only one requester active: that port is granted.
  - Both active: grant the port opposite last_gnt.
  - Neither active: no grant.
- Grant signals: p0_gnt/p1_gnt are mutually exclusive and asserted only when the matching req is high.
- last_gnt register:
  - Reset value 1, so port 0 wins the first conflict.
  - Loads the granted port index on every grant; holds when idle.
- Memory drive:
  - mem_a and mem_wd come from the granted port.
  - mem_we = granted port's we.
  - When idle: mem_we = 0, mem_a and mem_wd = port 0 values (harmless, since the memory reads every cycle).
- Read return:
  - A granted read sets pend_valid=1 and pend_id=port for the next cycle.
  - Next cycle: px_rvalid=1 for the owning port only; px_rdata = mem_rd.
  - Read latency is exactly 1 cycle from grant.
- Writes: single-cycle, acknowledged by gnt only; no rvalid.
- Non-owning port: px_rdata for a port without rvalid is don't-care, driven as mem_rd.
- Back-to-back: a new grant may be issued in the same cycle as the previous read's rvalid. Full throughput is 1 access/cycle.
- Same-address collision: read granted the cycle after a write to the same address returns the new data; the memory write lands before the next read edge.
- Fairness: under continuous requests on both ports, grants strictly alternate 0,1,0,1.
- Starvation: neither port waits more than 1 cycle.
- Requester rule: requesters must hold req/we/addr/wdata stable until gnt. The arbiter does not latch unsampled requests.
- Reset (asynchronous, at any time, including mid-read):
  - pend_valid=0, p0_rvalid=p1_rvalid=0, last_gnt=1.
  - A read in flight at reset is dropped; no rvalid after release.
- Registered outputs reset to 0. Combinational outputs follow inputs but gnt is forced 0 while rst_n=0.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- Defined:
  - Adds input stat_clr (1, synchronous clear) and outputs stat_gnt0, stat_gnt1, stat_conflict (STAT_W each).
  - stat_gnt0 / stat_gnt1 count grants per port; stat_conflict counts cycles with both req high.
  - Counters saturate at all-ones, reset to 0 on rst_n, and clear on stat_clr (clear wins over increment).
- Undefined: ports and counters are absent; arbitration behaviour is identical.

Decomposition:
- Package dmem_arb_pkg:
  - Port-index constants PORT_CORE=0, PORT_LOAD=1.
  - Typedef for the request bundle {we, addr, wdata}.
  - Default N/M constants.
- Sub-module rr_arb2: the 2-way round-robin grant logic plus the last_gnt register. The pending-read tracking, memory mux and stats stay in the top.

Test Plan:
- Reset release, p0 reads addr 0x00010 (mem holds 0xDEADBEEF) -> p0_gnt same cycle, p0_rvalid=1 with p0_rdata=0xDEADBEEF next cycle, p1_rvalid=0.
- Both ports request reads of 0x1 and 0x2 continuously for 6 cycles -> grants 0,1,0,1,0,1; each rvalid follows its grant by 1 cycle with the correct data.
- p1 writes 0x12345678 to 0x00020, then p0 reads 0x00020 next cycle -> p0_rdata=0x12345678; no rvalid on the write.
- p0 read granted, rst_n pulsed low mid-cycle before next edge -> rvalid stays 0 and last_gnt=1; the first conflict after reset grants p0.
- Idle 5 cycles -> mem_we=0 throughout, no gnt, no rvalid.
- With DMEM_ARB_STATS_EN: 10 conflict cycles then stat_clr -> stat_conflict=10, stat_gnt0=5, stat_gnt1=5, then all 0 the cycle after clr.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared constants and types for the two-port data-memory arbiter.
package dmem_arb_pkg;

    localparam int unsigned N_DEF      = 20;
    localparam int unsigned M_DEF      = 32;
    localparam int unsigned STAT_W_DEF = 32;

    localparam logic PORT_CORE = 1'b0;
    localparam logic PORT_LOAD = 1'b1;

    // One requester's access bundle at the default widths.
    typedef struct packed {
        logic              we;
        logic [N_DEF-1:0]  addr;
        logic [M_DEF-1:0]  wdata;
    } req_t;

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// Two-way round-robin grant with the last-granted-port register.
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    output logic [1:0] gnt_c
);

    logic last_gnt;

    // Conflicts go to the port that did not win last; grant is held off during reset.
    always_comb begin
        gnt_c = 2'b00;
        if (rst_n) begin
            if (req == 2'b11) begin
                gnt_c = (last_gnt == PORT_LOAD) ? 2'b01 : 2'b10;
            end else begin
                gnt_c = req;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT_LOAD;
        end else if (gnt_c != 2'b00) begin
            last_gnt <= gnt_c[1];
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter in front of a single-port synchronous data memory.
// Optional grant/conflict counters are enabled by defining DMEM_ARB_STATS_EN.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned N = N_DEF,
    parameter int unsigned M = M_DEF
`ifdef DMEM_ARB_STATS_EN
    ,
    parameter int unsigned STAT_W = STAT_W_DEF
`endif
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         p0_req,
    input  logic         p0_we,
    input  logic [N-1:0] p0_addr,
    input  logic [M-1:0] p0_wdata,
    output logic         p0_gnt,
    output logic         p0_rvalid,
    output logic [M-1:0] p0_rdata,
    input  logic         p1_req,
    input  logic         p1_we,
    input  logic [N-1:0] p1_addr,
    input  logic [M-1:0] p1_wdata,
    output logic         p1_gnt,
    output logic         p1_rvalid,
    output logic [M-1:0] p1_rdata,
    output logic         mem_we,
    output logic [N-1:0] mem_a,
    output logic [M-1:0] mem_wd,
    input  logic [M-1:0] mem_rd
`ifdef DMEM_ARB_STATS_EN
    ,
    input  logic              stat_clr,
    output logic [STAT_W-1:0] stat_gnt0,
    output logic [STAT_W-1:0] stat_gnt1,
    output logic [STAT_W-1:0] stat_conflict
`endif
);

    logic [1:0] gnt_c;
    logic       sel_id;
    logic       rd_issue;

    rr_arb2 u_rr_arb2 (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({p1_req, p0_req}),
        .gnt_c (gnt_c)
    );

    assign p0_gnt = gnt_c[0];
    assign p1_gnt = gnt_c[1];

    // Memory steering; idle cycles present port 0 with writes disabled.
    always_comb begin
        sel_id = PORT_CORE;
        mem_we = 1'b0;
        mem_a  = p0_addr;
        mem_wd = p0_wdata;
        if (gnt_c[1]) begin
            sel_id = PORT_LOAD;
            mem_we = p1_we;
            mem_a  = p1_addr;
            mem_wd = p1_wdata;
        end else if (gnt_c[0]) begin
            mem_we = p0_we;
        end
    end

    assign rd_issue = (gnt_c != 2'b00) && !mem_we;

    // Read data returns one cycle after grant, tagged to the owning port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p0_rvalid <= 1'b0;
            p1_rvalid <= 1'b0;
        end else begin
            p0_rvalid <= rd_issue && (sel_id == PORT_CORE);
            p1_rvalid <= rd_issue && (sel_id == PORT_LOAD);
        end
    end

    assign p0_rdata = mem_rd;
    assign p1_rdata = mem_rd;

`ifdef DMEM_ARB_STATS_EN
    localparam logic [STAT_W-1:0] STAT_MAX = {STAT_W{1'b1}};

    // Saturating counters; clear takes priority over counting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else if (stat_clr) begin
            stat_gnt0     <= '0;
            stat_gnt1     <= '0;
            stat_conflict <= '0;
        end else begin
            if (gnt_c[0] && (stat_gnt0 != STAT_MAX)) begin
                stat_gnt0 <= stat_gnt0 + STAT_W'(1);
            end
            if (gnt_c[1] && (stat_gnt1 != STAT_MAX)) begin
                stat_gnt1 <= stat_gnt1 + STAT_W'(1);
            end
            if (p0_req && p1_req && (stat_conflict != STAT_MAX)) begin
                stat_conflict <= stat_conflict + STAT_W'(1);
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus random traffic against a reference model.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [19:0] p0_addr, p1_addr;
    logic [31:0] p0_wdata, p1_wdata;
    logic        p0_gnt, p0_rvalid, p1_gnt, p1_rvalid;
    logic [31:0] p0_rdata, p1_rdata;
    logic        mem_we;
    logic [19:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;
`ifdef DMEM_ARB_STATS_EN
    logic        stat_clr;
    logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
    int          m_g0, m_g1, m_conf;
`endif

    dmem_arbiter dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_wdata  (p0_wdata),
        .p0_gnt    (p0_gnt),
        .p0_rvalid (p0_rvalid),
        .p0_rdata  (p0_rdata),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_wdata  (p1_wdata),
        .p1_gnt    (p1_gnt),
        .p1_rvalid (p1_rvalid),
        .p1_rdata  (p1_rdata),
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_wd    (mem_wd),
        .mem_rd    (mem_rd)
`ifdef DMEM_ARB_STATS_EN
        ,
        .stat_clr      (stat_clr),
        .stat_gnt0     (stat_gnt0),
        .stat_gnt1     (stat_gnt1),
        .stat_conflict (stat_conflict)
`endif
    );

    always #5 clk = ~clk;

    // Memory under the arbiter: synchronous read and write, read returns old data.
    logic [31:0] mem [0:255];
    always @(posedge clk) begin
        if (mem_we) mem[mem_a[7:0]] <= mem_wd;
        mem_rd <= mem[mem_a[7:0]];
    end

    // Reference state: expected memory contents, last winner, pending read.
    logic [31:0] ref_mem [0:255];
    int          exp_last;
    bit          exp_rv0, exp_rv1;
    logic [31:0] exp_rd;
    int          nvec = 0;
    int          nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_last = 1;
        exp_rv0  = 1'b0;
        exp_rv1  = 1'b0;
`ifdef DMEM_ARB_STATS_EN
        m_g0 = 0; m_g1 = 0; m_conf = 0;
`endif
    endtask

    // Checks current outputs against the model, then advances the model by one cycle.
    task automatic check_and_model(output int win);
        logic        wwe;
        logic [19:0] wa;
        logic [31:0] wd;
        chk("p0_rvalid", 64'(p0_rvalid), 64'(exp_rv0));
        chk("p1_rvalid", 64'(p1_rvalid), 64'(exp_rv1));
        if (exp_rv0) chk("p0_rdata", 64'(p0_rdata), 64'(exp_rd));
        if (exp_rv1) chk("p1_rdata", 64'(p1_rdata), 64'(exp_rd));
`ifdef DMEM_ARB_STATS_EN
        chk("stat_gnt0", 64'(stat_gnt0), 64'(m_g0));
        chk("stat_gnt1", 64'(stat_gnt1), 64'(m_g1));
        chk("stat_conflict", 64'(stat_conflict), 64'(m_conf));
`endif
        if (p0_req && p1_req) win = 1 - exp_last;
        else if (p0_req)      win = 0;
        else if (p1_req)      win = 1;
        else                  win = -1;
        chk("p0_gnt", 64'(p0_gnt), 64'(win == 0));
        chk("p1_gnt", 64'(p1_gnt), 64'(win == 1));
        if (win == 1) begin
            wwe = p1_we; wa = p1_addr; wd = p1_wdata;
        end else begin
            wwe = (win == 0) ? p0_we : 1'b0; wa = p0_addr; wd = p0_wdata;
        end
        chk("mem_we", 64'(mem_we), 64'(wwe));
        chk("mem_a", 64'(mem_a), 64'(wa));
        if (wwe || win == -1) chk("mem_wd", 64'(mem_wd), 64'(wd));
        exp_rv0 = (win == 0) && !wwe;
        exp_rv1 = (win == 1) && !wwe;
        if (win >= 0) begin
            exp_rd = ref_mem[wa[7:0]];
            if (wwe) ref_mem[wa[7:0]] = wd;
            exp_last = win;
        end
`ifdef DMEM_ARB_STATS_EN
        if (stat_clr) begin
            m_g0 = 0; m_g1 = 0; m_conf = 0;
        end else begin
            if (win == 0) m_g0++;
            if (win == 1) m_g1++;
            if (p0_req && p1_req) m_conf++;
        end
`endif
    endtask

    task automatic cycle(input bit r0, input bit w0, input logic [19:0] a0, input logic [31:0] d0,
                         input bit r1, input bit w1, input logic [19:0] a1, input logic [31:0] d1,
                         output int win);
        @(negedge clk);
        p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
        p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
        #1;
        check_and_model(win);
    endtask

    initial begin
        int          win;
        int          w0c, w1c;
        bit          cr0, cw0, cr1, cw1;
        logic [19:0] ca0, ca1;
        logic [31:0] cd0, cd1;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
            ref_mem[i] = 32'(i) * 32'h0101_0101 ^ 32'hA5A5_0000;
        end
        mem[8'h10]     = 32'hDEAD_BEEF;
        ref_mem[8'h10] = 32'hDEAD_BEEF;
`ifdef DMEM_ARB_STATS_EN
        stat_clr = 1'b0;
`endif
        // Reset: grant forced low even with a request present.
        rst_n = 1'b0;
        p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h0; p0_wdata = 32'h0;
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h0; p1_wdata = 32'h0;
        model_reset();
        #6;
        chk("rst_p0_gnt", 64'(p0_gnt), 64'(0));
        chk("rst_p1_gnt", 64'(p1_gnt), 64'(0));
        chk("rst_p0_rvalid", 64'(p0_rvalid), 64'(0));
        chk("rst_p1_rvalid", 64'(p1_rvalid), 64'(0));
        p0_req = 1'b0; p1_req = 1'b0;
        #1 rst_n = 1'b1;

        // Single read from port 0.
        cycle(1, 0, 20'h00010, 0, 0, 0, 0, 0, win);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);

        // Continuous conflicting reads: grants must alternate.
        for (int i = 0; i < 6; i++) cycle(1, 0, 20'h1, 0, 1, 0, 20'h2, 0, win);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);

        // Write by port 1, then read-after-write by port 0.
        cycle(0, 0, 0, 0, 1, 1, 20'h00020, 32'h1234_5678, win);
        cycle(1, 0, 20'h00020, 0, 0, 0, 0, 0, win);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        chk("raw_data_seen", 64'(mem[8'h20]), 64'(32'h1234_5678));

        // Reset pulse while a read is in flight.
        cycle(1, 0, 20'h00030, 0, 0, 0, 0, 0, win);
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_p0_gnt", 64'(p0_gnt), 64'(0));
        p0_req = 1'b0;
        model_reset();
        #1 rst_n = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        cycle(1, 0, 20'h3, 0, 1, 0, 20'h4, 0, win);
        chk("post_rst_first_conflict", 64'(p0_gnt), 64'(1));
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);

        // Idle stretch.
        for (int i = 0; i < 5; i++) cycle(0, 0, 20'h5, 32'h55, 0, 0, 20'h6, 32'h66, win);

`ifdef DMEM_ARB_STATS_EN
        stat_clr = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        stat_clr = 1'b0;
        for (int i = 0; i < 10; i++) cycle(1, 0, 20'h1, 0, 1, 0, 20'h2, 0, win);
        stat_clr = 1'b1;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        chk("stat_conflict_10", 64'(stat_conflict), 64'(10));
        chk("stat_gnt0_5", 64'(stat_gnt0), 64'(5));
        chk("stat_gnt1_5", 64'(stat_gnt1), 64'(5));
        stat_clr = 1'b0;
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        chk("stat_cleared", 64'(stat_gnt0 | stat_gnt1 | stat_conflict), 64'(0));
`endif

        // Random traffic; each requester holds its request until granted.
        cr0 = 0; cw0 = 0; ca0 = 0; cd0 = 0; cr1 = 0; cw1 = 0; ca1 = 0; cd1 = 0;
        w0c = 0; w1c = 0;
        for (int i = 0; i < 300; i++) begin
            cycle(cr0, cw0, ca0, cd0, cr1, cw1, ca1, cd1, win);
            w0c = (cr0 && !p0_gnt) ? w0c + 1 : 0;
            w1c = (cr1 && !p1_gnt) ? w1c + 1 : 0;
            chk("starve0", 64'(w0c <= 1), 64'(1));
            chk("starve1", 64'(w1c <= 1), 64'(1));
            if (win == 0 || !cr0) begin
                cr0 = ($urandom % 4) != 0;
                cw0 = ($urandom % 3) == 0;
                ca0 = 20'($urandom % 16);
                cd0 = $urandom;
            end
            if (win == 1 || !cr1) begin
                cr1 = ($urandom % 4) != 0;
                cw1 = ($urandom % 3) == 0;
                ca1 = 20'($urandom % 16);
                cd1 = $urandom;
            end
        end
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);
        cycle(0, 0, 0, 0, 0, 0, 0, 0, win);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
